updown_sweep_ctrl: RTL and testbench
====================================

// Module: updown_sweep_ctrl
// PURPOSE
//  Sequencer for a WIDTH-bit synchronous up/down counter. Generates a repeating triangle sweep lo->hi->lo.
//  Supports a programmable dwell at each turning point and a programmable sweep count.
//  Start/stop control, busy/done status. Sits between a config/control master and the counter datapath.
// PARAMETERS
//  WIDTH      4   counter / limit width
//  CYC_W      8   width of sweep-count and sweep-counter
//  HOLD_W     4   width of dwell-length field
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high; clears all state
//  start       in   1       level sampled each cycle; acted on only in IDLE
//  stop        in   1       abort request; acted on only when busy
//  lo_limit    in   WIDTH   sweep floor, latched at start
//  hi_limit    in   WIDTH   sweep ceiling, latched at start
//  cycles      in   CYC_W   full lo->hi->lo sweeps to run; 0 = run until stop
//  hold        in   HOLD_W  extra cycles count is held at hi and at lo turns
//  count       out  WIDTH   current counter value
//  up_downbar  out  1       direction of next step: 1 = up, 0 = down
//  busy        out  1       high while sweeping
//  turn        out  1       1-cycle pulse: count just reached an extreme and the sweep continues
//  done        out  1       1-cycle pulse: sweep finished or aborted
//  err         out  1       1-cycle pulse: start rejected because lo_limit >= hi_limit
// BEHAVIOUR
//  Reset values: count=0, up_downbar=1, busy=0, turn=0, done=0, err=0, state=IDLE, sweep counter=0.
//    Reset mid-sweep aborts with no done pulse.
//  FSM states: IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
//  IDLE:
//    - start=1 with lo<hi: latch lo, hi, cycles, hold.
//    - Next cycle: count=lo, up_downbar=1, busy=1, state=UP, sweep counter=0.
//    - start=1 with lo>=hi: err=1 next cycle; all other outputs unchanged; stay IDLE.
//  UP: count+1 each cycle.
//    - On the edge where count becomes hi: up_downbar=0, turn=1.
//    - Then go to DOWN (hold=0) or to DWELL_HI with dwell counter=hold.
//  DWELL_HI: count frozen; decrement the dwell counter; go to DOWN on the edge after it reaches 0.
//    - hi is visible for hold+1 cycles.
//  DOWN: count-1 each cycle. On the edge where count becomes lo, increment the sweep counter:
//    - Final sweep (cycles!=0 and new sweep counter==cycles): state=IDLE, busy=0, done=1, turn=0.
//    - Otherwise: up_downbar=1, turn=1, then go to UP (hold=0) or to DWELL_LO (symmetric with DWELL_HI).
//  stop=1 in any busy state:
//    - Next edge: state=IDLE, busy=0, done=1.
//    - count and up_downbar frozen.
//    - stop has priority over the step/turn in the same cycle.
//  start is ignored while busy. stop is ignored in IDLE. In IDLE, count holds its last value.
//  turn, done and err are registered and high for exactly one cycle.
//  No wrap-around: lo<hi is enforced and limits are latched, so count stays within [lo,hi].
//    lo=0 / hi=2^WIDTH-1 are legal.
//  Sweep counter is CYC_W bits; with cycles=0 it may wrap freely without effect.
// STRUCTURE
//  Package updown_sweep_pkg: FSM state encoding (localparams), default WIDTH/CYC_W/HOLD_W.
//  Sub-module updown_count_core:
//    - WIDTH-bit register with load (value), enable, and direction inputs.
//    - Output is count.
//  The controller FSM drives load, enable and direction of updown_count_core, plus the dwell counter,
//  the sweep counter and the status pulses.
// TESTING
//  1. lo=2,hi=5,hold=0,cycles=1, start 1 cycle -> count 2,3,4,5,4,3,2.
//     turn pulse at the 5 only; done with the final 2; busy high 6 cycles; up_downbar=0 from the 5 onward.
//  2. lo=0,hi=3,hold=2,cycles=2 -> count 0,1,2,3,3,3,2,1,0,0,0,1,2,3,3,3,2,1,0.
//     turn pulses at the first 3s and the middle 0; done on the last 0.
//  3. lo=5,hi=5 start -> err pulse 1 cycle, busy=0, count unchanged.
//     Then lo=9,hi=4 start -> err again.
//  4. lo=1,hi=4,cycles=0, stop after 20 busy cycles -> count frozen, done 1 cycle, busy 0.
//     Also: start asserted mid-sweep is ignored; a restart afterwards begins at count=1.
//  5. lo=0,hi=15,cycles=0; reset for 1 cycle at count=9 -> next cycle count=0, up_downbar=1, busy=0, no done.
//  6. lo=0,hi=15 (full range) -> sequence ...14,15,14...1,0,1 with no wrap past 15 or below 0.
//     stop and a turn in the same cycle -> done, no turn.

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// rtl/updown_sweep_pkg.sv - shared state encoding and default widths for the up/down sweep sequencer
package updown_sweep_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int CYC_W_DEF  = 8;
  localparam int HOLD_W_DEF = 4;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_UP_ENC       = 3'd1;
  localparam logic [2:0] ST_DWELL_HI_ENC = 3'd2;
  localparam logic [2:0] ST_DOWN_ENC     = 3'd3;
  localparam logic [2:0] ST_DWELL_LO_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_UP       = ST_UP_ENC,
    ST_DWELL_HI = ST_DWELL_HI_ENC,
    ST_DOWN     = ST_DOWN_ENC,
    ST_DWELL_LO = ST_DWELL_LO_ENC
  } state_e;

endpackage

// File: rtl/updown_count_core.sv
// rtl/updown_count_core.sv - loadable WIDTH-bit up/down counter register
module updown_count_core
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over a step so a start always lands exactly on the floor.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = up_i ? (count_q + 1'b1) : (count_q - 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - triangle sweep sequencer with turn dwell, sweep count and start/stop control
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CYC_W  = CYC_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [WIDTH-1:0]  lo_limit_i,
  input  logic [WIDTH-1:0]  hi_limit_i,
  input  logic [CYC_W-1:0]  cycles_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              up_downbar_o,
  output logic              busy_o,
  output logic              turn_o,
  output logic              done_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] dwell_q, dwell_d;
  logic [CYC_W-1:0]  sweep_q, sweep_d;
  logic              updn_q, updn_d;
  logic              turn_q, turn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              core_load;
  logic              core_en;
  logic              core_up;
  logic [WIDTH-1:0]  count_w;
  logic [WIDTH-1:0]  cnt_inc;
  logic [WIDTH-1:0]  cnt_dec;
  logic [CYC_W-1:0]  sweep_inc;
  logic              do_up;
  logic              do_dn;

  updown_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (core_load),
    .load_val_i (lo_limit_i),
    .en_i       (core_en),
    .up_i       (core_up),
    .count_o    (count_w)
  );

  assign cnt_inc   = count_w + 1'b1;
  assign cnt_dec   = count_w - 1'b1;
  assign sweep_inc = sweep_q + 1'b1;

  // An expiring dwell takes the next step itself, so a turn shows for exactly hold+1 cycles.
  assign do_up = (state_q == ST_UP)   || ((state_q == ST_DWELL_LO) && (dwell_q == '0));
  assign do_dn = (state_q == ST_DOWN) || ((state_q == ST_DWELL_HI) && (dwell_q == '0));

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cyc_d     = cyc_q;
    hold_d    = hold_q;
    dwell_d   = dwell_q;
    sweep_d   = sweep_q;
    updn_d    = updn_q;
    turn_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_up   = updn_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (lo_limit_i < hi_limit_i) begin
            lo_d      = lo_limit_i;
            hi_d      = hi_limit_i;
            cyc_d     = cycles_i;
            hold_d    = hold_i;
            sweep_d   = '0;
            updn_d    = 1'b1;
            core_load = 1'b1;
            state_d   = ST_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (do_up) begin
          core_en = 1'b1;
          core_up = 1'b1;
          state_d = ST_UP;
          if (cnt_inc == hi_q) begin
            updn_d  = 1'b0;
            turn_d  = 1'b1;
            dwell_d = hold_q;
            state_d = (hold_q == '0) ? ST_DOWN : ST_DWELL_HI;
          end
        end else if (do_dn) begin
          core_en = 1'b1;
          core_up = 1'b0;
          state_d = ST_DOWN;
          if (cnt_dec == lo_q) begin
            sweep_d = sweep_inc;
            if ((cyc_q != '0) && (sweep_inc == cyc_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              updn_d  = 1'b1;
              turn_d  = 1'b1;
              dwell_d = hold_q;
              state_d = (hold_q == '0) ? ST_UP : ST_DWELL_LO;
            end
          end
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      cyc_q   <= '0;
      hold_q  <= '0;
      dwell_q <= '0;
      sweep_q <= '0;
      updn_q  <= 1'b1;
      turn_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cyc_q   <= cyc_d;
      hold_q  <= hold_d;
      dwell_q <= dwell_d;
      sweep_q <= sweep_d;
      updn_q  <= updn_d;
      turn_q  <= turn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign count_o      = count_w;
  assign up_downbar_o = updn_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign turn_o       = turn_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - scoreboard bench for the up/down sweep sequencer
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [7:0] cycles;
  logic [3:0] hold;
  logic [3:0] count;
  logic       updn;
  logic       busy;
  logic       turn;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic       busy;
    logic       turn;
    logic       done;
    logic       err;
    logic       updn;
  } obs_t;

  obs_t exp_q[$];

  updown_sweep_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .stop_i       (stop),
    .lo_limit_i   (lo),
    .hi_limit_i   (hi),
    .cycles_i     (cycles),
    .hold_i       (hold),
    .count_o      (count),
    .up_downbar_o (updn),
    .busy_o       (busy),
    .turn_o       (turn),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int c, input bit b, input bit t, input bit d, input bit u);
    obs_t o;
    o.cnt  = c[3:0];
    o.busy = b;
    o.turn = t;
    o.done = d;
    o.err  = 1'b0;
    o.updn = u;
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.cnt  = count;
    o.busy = busy;
    o.turn = turn;
    o.done = done;
    o.err  = err;
    o.updn = updn;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("cnt=%0d busy=%b turn=%b done=%b err=%b ud=%b",
                     o.cnt, o.busy, o.turn, o.done, o.err, o.updn);
  endfunction

  // Builds the expected triangle directly from the sweep description, one entry per cycle.
  task automatic gen_sweep(input int l, input int h, input int hd, input int c, input int limit);
    bit fin = 1'b0;
    exp_q.push_back(mk(l, 1, 0, 0, 1));
    for (int s = 1; !fin && exp_q.size() < limit; s++) begin
      for (int v = l + 1; v <= h; v++) exp_q.push_back(mk(v, 1, v == h, 0, v != h));
      repeat (hd) exp_q.push_back(mk(h, 1, 0, 0, 0));
      for (int v = h - 1; v > l; v--) exp_q.push_back(mk(v, 1, 0, 0, 0));
      if (c != 0 && s == c) begin
        exp_q.push_back(mk(l, 0, 0, 1, 0));
        fin = 1'b1;
      end else begin
        exp_q.push_back(mk(l, 1, 1, 0, 1));
        repeat (hd) exp_q.push_back(mk(l, 1, 0, 0, 1));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l, input int h, input int c, input int hd);
    lo     = l[3:0];
    hi     = h[3:0];
    cycles = c[7:0];
    hold   = hd[3:0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    obs_t e;
    reset = 1'b1;
    tick();
    tick();
    o = cur();
    e = mk(0, 0, 0, 0, 1);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL reset_state: got %s need %s", fmt(o), fmt(e));
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_sweep();
    obs_t o;
    obs_t e;
    int   vals[7] = '{2, 3, 4, 5, 4, 3, 2};
    for (int i = 0; i < 7; i++)
      exp_q.push_back(mk(vals[i], i < 6, i == 3, i == 6, i < 3));
    exp_q.push_back(mk(2, 0, 0, 0, 0));
    do_start(2, 5, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = cur();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL single_sweep step %0d: got %s need %s", i, fmt(o), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_dwell_two_sweeps();
    obs_t o;
    obs_t e;
    gen_sweep(0, 3, 2, 2, 100);
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    do_start(0, 3, 2, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = cur();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL dwell_sweep step %0d: got %s need %s", i, fmt(o), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_err();
    obs_t o;
    obs_t e;
    int   los[2] = '{5, 9};
    int   his[2] = '{5, 4};
    for (int k = 0; k < 2; k++) begin
      do_start(los[k], his[k], 1, 0);
      o = cur();
      e = mk(0, 0, 0, 0, 0);
      e.err = 1'b1;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL err_pulse %0d: got %s need %s", k, fmt(o), fmt(e));
      end
      tick();
      o = cur();
      e = mk(0, 0, 0, 0, 0);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL err_clear %0d: got %s need %s", k, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_stop_and_restart();
    obs_t o;
    obs_t e;
    obs_t f;
    gen_sweep(1, 4, 0, 0, 24);
    do_start(1, 4, 0, 0);
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      o = cur();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL stop_run step %0d: got %s need %s", i, fmt(o), fmt(e));
      end
      if (i == 5) begin
        lo    = 4'd0;
        hi    = 4'd9;
        start = 1'b1;
      end
      if (i == 8) start = 1'b0;
      if (i == 19) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    exp_q.delete();
    f = e;
    f.busy = 1'b0;
    f.turn = 1'b0;
    f.done = 1'b1;
    o = cur();
    total++;
    if (o !== f) begin
      bad++;
      $display("FAIL stop_frozen: got %s need %s", fmt(o), fmt(f));
    end
    tick();
    f.done = 1'b0;
    o = cur();
    total++;
    if (o !== f) begin
      bad++;
      $display("FAIL stop_done_once: got %s need %s", fmt(o), fmt(f));
    end
    do_start(1, 4, 0, 0);
    e = mk(1, 1, 0, 0, 1);
    o = cur();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL restart: got %s need %s", fmt(o), fmt(e));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    e = mk(1, 0, 0, 1, 1);
    o = cur();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL restart_stop: got %s need %s", fmt(o), fmt(e));
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    obs_t o;
    obs_t e;
    gen_sweep(0, 15, 0, 0, 12);
    do_start(0, 15, 0, 0);
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      o = cur();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL pre_reset step %0d: got %s need %s", i, fmt(o), fmt(e));
      end
      if (i == 9) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      e = mk(0, 0, 0, 0, 1);
      o = cur();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL mid_reset %0d: got %s need %s", k, fmt(o), fmt(e));
      end
      tick();
    end
  endtask

  task automatic test_full_range_stop_on_turn();
    obs_t o;
    obs_t e;
    obs_t f;
    gen_sweep(0, 15, 0, 0, 50);
    do_start(0, 15, 0, 0);
    for (int i = 0; i < 45; i++) begin
      e = exp_q.pop_front();
      o = cur();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL full_range step %0d: got %s need %s", i, fmt(o), fmt(e));
      end
      if (i == 44) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    exp_q.delete();
    f = mk(14, 0, 0, 1, 1);
    o = cur();
    total++;
    if (o !== f) begin
      bad++;
      $display("FAIL stop_on_turn: got %s need %s", fmt(o), fmt(f));
    end
    tick();
    f.done = 1'b0;
    o = cur();
    total++;
    if (o !== f) begin
      bad++;
      $display("FAIL stop_on_turn_after: got %s need %s", fmt(o), fmt(f));
    end
  endtask

  task automatic test_adjacent_limits();
    obs_t o;
    obs_t e;
    gen_sweep(7, 8, 1, 2, 100);
    exp_q.push_back(mk(7, 0, 0, 0, 0));
    do_start(7, 8, 2, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = cur();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL adjacent step %0d: got %s need %s", i, fmt(o), fmt(e));
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    lo     = 4'd0;
    hi     = 4'd0;
    cycles = 8'd0;
    hold   = 4'd0;
    test_reset();
    test_single_sweep();
    test_dwell_two_sweeps();
    test_err();
    test_stop_and_restart();
    test_reset_mid_sweep();
    test_full_range_stop_on_turn();
    test_adjacent_limits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
